// File: rtl/udp_csum_check_if.sv
// Byte-stream and result bundle for the receive-side UDP/IP checksum verifier.
// The upstream parser drives the master side; the checker is the slave.
interface udp_csum_check_if;
    logic [7:0]  d;
    logic        data_en;
    logic        last;
    logic [15:0] seed;
    logic        rdy_o;
    logic        busy_o;
    logic        done_o;
    logic        ok_o;
    logic [15:0] csum_o;
    logic [15:0] byte_cnt_o;

    modport master (
        output d, data_en, last, seed,
        input  rdy_o, busy_o, done_o, ok_o, csum_o, byte_cnt_o
    );

    modport slave (
        input  d, data_en, last, seed,
        output rdy_o, busy_o, done_o, ok_o, csum_o, byte_cnt_o
    );
endinterface

// File: rtl/udp_csum_check.sv
// RFC 1071 ones'-complement checksum verifier over a big-endian byte stream.
// Frames carry their own checksum field; ok_o flags a final sum of 16'hFFFF.
module udp_csum_check (
    input  logic              clk_i,
    input  logic              rst_n,
    udp_csum_check_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, ACC, FOLD, DONE} state_t;

    state_t      state, state_nxt;
    logic        accept;
    logic        frame_start;
    logic [15:0] fold_sum;

    logic [15:0] acc;
    logic [7:0]  pend;
    logic        hi_pend;
    logic        pad_pend;
    logic [15:0] byte_cnt;
    logic        busy;
    logic        done;
    logic        ok;
    logic [15:0] csum;

    // 16-bit add with the carry folded back in; the result never carries again.
    function automatic logic [15:0] eac_add(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[15:0] + {15'd0, s[16]};
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] c);
        return (c == 16'hFFFF) ? c : c + 16'd1;
    endfunction

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        accept      = bus.data_en && (state != FOLD);
        frame_start = accept && ((state == IDLE) || (state == DONE));
        fold_sum    = pad_pend ? eac_add(acc, {pend, 8'h00}) : acc;
        state_nxt   = state;
        case (state)
            IDLE: if (accept) state_nxt = bus.last ? FOLD : ACC;
            ACC:  if (accept && bus.last) state_nxt = FOLD;
            FOLD: state_nxt = DONE;
            DONE: begin
                if (accept) state_nxt = bus.last ? FOLD : ACC;
                else        state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Even-position bytes wait as the high half; odd-position bytes complete a word.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            acc      <= 16'h0000;
            pend     <= 8'h00;
            hi_pend  <= 1'b0;
            pad_pend <= 1'b0;
            byte_cnt <= 16'h0000;
            busy     <= 1'b0;
            done     <= 1'b0;
            ok       <= 1'b0;
            csum     <= 16'h0000;
        end else begin
            done <= (state_nxt == DONE);
            busy <= (state_nxt == ACC) || (state_nxt == FOLD);
            if (frame_start) begin
                acc      <= bus.seed;
                byte_cnt <= 16'd1;
                pend     <= bus.d;
                hi_pend  <= 1'b1;
                pad_pend <= bus.last;
            end else if (accept) begin
                byte_cnt <= sat_inc(byte_cnt);
                if (hi_pend) begin
                    acc      <= eac_add(acc, {pend, bus.d});
                    hi_pend  <= 1'b0;
                    pad_pend <= 1'b0;
                end else begin
                    pend     <= bus.d;
                    hi_pend  <= 1'b1;
                    pad_pend <= bus.last;
                end
            end else if (state == FOLD) begin
                acc      <= fold_sum;
                hi_pend  <= 1'b0;
                pad_pend <= 1'b0;
                ok       <= (fold_sum == 16'hFFFF);
                csum     <= ~fold_sum;
            end
        end
    end

    assign bus.rdy_o      = (state != FOLD);
    assign bus.busy_o     = busy;
    assign bus.done_o     = done;
    assign bus.ok_o       = ok;
    assign bus.csum_o     = csum;
    assign bus.byte_cnt_o = byte_cnt;
endmodule

// File: tb/tb_udp_csum_check.sv
// Randomized and directed bench for udp_csum_check against a whole-frame
// ones'-complement reference computed with plain integer arithmetic.
module tb_udp_csum_check;
    logic clk_i = 1'b0;
    logic rst_n = 1'b0;
    udp_csum_check_if bus ();

    udp_csum_check dut (.clk_i(clk_i), .rst_n(rst_n), .bus(bus));

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] frm [0:127];
    int frm_len;

    // Sum every big-endian word of the frame plus seed, then fold all carries at the end.
    function automatic logic [15:0] ref_sum(input logic [15:0] sd);
        longint t;
        t = sd;
        for (int i = 0; i < frm_len; i += 2)
            t += (i + 1 < frm_len) ? {frm[i], frm[i+1]} : {frm[i], 8'h00};
        while ((t >> 16) != 0) t = (t & 64'hFFFF) + (t >> 16);
        return t[15:0];
    endfunction

    task automatic tick();
        @(posedge clk_i); #1;
    endtask

    task automatic send_frame(input logic [15:0] sd, input int gap_pct, input string nm);
        logic [15:0] exp_sum;
        exp_sum = ref_sum(sd);
        for (int i = 0; i < frm_len; i++) begin
            if ($urandom_range(99) < gap_pct) begin
                repeat ($urandom_range(3, 1)) begin
                    bus.data_en = 1'b0; bus.d = 8'($urandom); bus.last = 1'($urandom);
                    tick();
                end
            end
            bus.d = frm[i]; bus.data_en = 1'b1; bus.last = (i == frm_len - 1);
            bus.seed = (i == 0) ? sd : 16'($urandom);
            n_cmp++;
            if (bus.rdy_o !== 1'b1) begin n_err++; $display("FAIL %s rdy byte %0d: got %b want 1", nm, i, bus.rdy_o); end
            tick();
            n_cmp++;
            if (bus.byte_cnt_o !== 16'(i + 1)) begin
                n_err++; $display("FAIL %s byte_cnt after byte %0d: got %0d want %0d", nm, i, bus.byte_cnt_o, i + 1);
            end
        end
        bus.data_en = 1'b0; bus.last = 1'b0;
        n_cmp++;
        if ({bus.rdy_o, bus.busy_o, bus.done_o} !== 3'b010) begin
            n_err++; $display("FAIL %s fold cycle rdy/busy/done: got %b want 010", nm, {bus.rdy_o, bus.busy_o, bus.done_o});
        end
        tick();
        n_cmp++;
        if (bus.done_o !== 1'b1) begin n_err++; $display("FAIL %s done latency: got %b want 1", nm, bus.done_o); end
        n_cmp++;
        if (bus.ok_o !== (exp_sum == 16'hFFFF)) begin
            n_err++; $display("FAIL %s ok: got %b want %b", nm, bus.ok_o, exp_sum == 16'hFFFF);
        end
        n_cmp++;
        if (bus.csum_o !== ~exp_sum) begin n_err++; $display("FAIL %s csum: got %h want %h", nm, bus.csum_o, ~exp_sum); end
        n_cmp++;
        if (bus.byte_cnt_o !== 16'(frm_len)) begin
            n_err++; $display("FAIL %s byte_cnt final: got %0d want %0d", nm, bus.byte_cnt_o, frm_len);
        end
    endtask

    task automatic load_hdr(input logic [15:0] ck);
        logic [15:0] w [0:9];
        w = '{16'h4500, 16'h0073, 16'h0000, 16'h4000, 16'h4011, ck, 16'hC0A8, 16'h0001, 16'hC0A8, 16'h00C7};
        for (int i = 0; i < 10; i++) begin frm[2*i] = w[i][15:8]; frm[2*i+1] = w[i][7:0]; end
        frm_len = 20;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        n_cmp++;
        if ({bus.rdy_o, bus.busy_o, bus.done_o, bus.ok_o} !== 4'b1000) begin
            n_err++; $display("FAIL reset flags rdy/busy/done/ok: got %b want 1000", {bus.rdy_o, bus.busy_o, bus.done_o, bus.ok_o});
        end
        n_cmp++;
        if (bus.csum_o !== 16'h0000) begin n_err++; $display("FAIL reset csum: got %h want 0000", bus.csum_o); end
        n_cmp++;
        if (bus.byte_cnt_o !== 16'h0000) begin n_err++; $display("FAIL reset byte_cnt: got %h want 0000", bus.byte_cnt_o); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_ipv4();
        load_hdr(16'hB861);
        send_frame(16'h0000, 0, "ipv4_good");
        n_cmp++;
        if ({bus.ok_o, bus.csum_o, bus.byte_cnt_o} !== {1'b1, 16'h0000, 16'd20}) begin
            n_err++; $display("FAIL ipv4_good const: got ok=%b csum=%h cnt=%0d want 1/0000/20", bus.ok_o, bus.csum_o, bus.byte_cnt_o);
        end
        tick();
        load_hdr(16'h0000);
        send_frame(16'h0000, 20, "ipv4_zeroed");
        n_cmp++;
        if ({bus.ok_o, bus.csum_o} !== {1'b0, 16'hB861}) begin
            n_err++; $display("FAIL ipv4_zeroed const: got ok=%b csum=%h want 0/B861", bus.ok_o, bus.csum_o);
        end
        tick();
        n_cmp++;
        if ({bus.done_o, bus.busy_o, bus.rdy_o} !== 3'b001) begin
            n_err++; $display("FAIL done_pulse_width done/busy/rdy: got %b want 001", {bus.done_o, bus.busy_o, bus.rdy_o});
        end
    endtask

    task automatic test_odd_and_carry();
        frm[0] = 8'h01; frm[1] = 8'h02; frm[2] = 8'h03; frm_len = 3;
        send_frame(16'h0000, 0, "odd_len");
        n_cmp++;
        if ({bus.ok_o, bus.csum_o} !== {1'b0, 16'hFBFD}) begin
            n_err++; $display("FAIL odd_len const: got ok=%b csum=%h want 0/FBFD", bus.ok_o, bus.csum_o);
        end
        frm[0] = 8'h00; frm[1] = 8'h01; frm_len = 2;
        send_frame(16'hFFFF, 0, "carry_wrap");
        n_cmp++;
        if (bus.csum_o !== 16'hFFFE) begin n_err++; $display("FAIL carry_wrap const: got csum=%h want FFFE", bus.csum_o); end
        send_frame(16'hFFFE, 0, "carry_ok");
        n_cmp++;
        if (bus.ok_o !== 1'b1) begin n_err++; $display("FAIL carry_ok const: got ok=%b want 1", bus.ok_o); end
        frm[0] = 8'hA5; frm_len = 1;
        send_frame(16'h1234, 0, "single_byte");
    endtask

    task automatic test_random();
        logic [15:0] sd, s;
        for (int f = 0; f < 30; f++) begin
            frm_len = $urandom_range(40, 1);
            for (int i = 0; i < frm_len; i++) frm[i] = 8'($urandom);
            sd = 16'($urandom);
            if (f % 7 == 3) sd = 16'hFFFF;
            if ((frm_len % 2 == 0) && (f % 2 == 0)) begin
                frm[frm_len-2] = 8'h00; frm[frm_len-1] = 8'h00;
                s = ~ref_sum(sd);
                frm[frm_len-2] = s[15:8]; frm[frm_len-1] = s[7:0];
            end
            send_frame(sd, 30, $sformatf("rand%0d", f));
            if (f % 3 == 0) tick();
        end
    endtask

    task automatic test_back_to_back();
        bus.d = 8'h12; bus.data_en = 1'b1; bus.last = 1'b0; bus.seed = 16'h1111; tick();
        bus.d = 8'h34; bus.last = 1'b1; bus.seed = 16'h0BAD; tick();
        bus.d = 8'hAA; bus.last = 1'b1; bus.seed = 16'h0000;
        n_cmp++;
        if (bus.rdy_o !== 1'b0) begin n_err++; $display("FAIL b2b fold rdy: got %b want 0", bus.rdy_o); end
        tick();
        n_cmp++;
        if ({bus.done_o, bus.ok_o, bus.csum_o, bus.byte_cnt_o} !== {1'b1, 1'b0, 16'hDCBA, 16'd2}) begin
            n_err++; $display("FAIL b2b frame_a: got done=%b ok=%b csum=%h cnt=%0d want 1/0/DCBA/2",
                              bus.done_o, bus.ok_o, bus.csum_o, bus.byte_cnt_o);
        end
        bus.d = 8'h00; bus.last = 1'b0; bus.seed = 16'hF0F0; tick();
        n_cmp++;
        if ({bus.done_o, bus.busy_o, bus.csum_o, bus.byte_cnt_o} !== {1'b0, 1'b1, 16'hDCBA, 16'd1}) begin
            n_err++; $display("FAIL b2b frame_b_start: got done=%b busy=%b csum=%h cnt=%0d want 0/1/DCBA/1",
                              bus.done_o, bus.busy_o, bus.csum_o, bus.byte_cnt_o);
        end
        bus.d = 8'h01; bus.seed = 16'h0000; tick();
        bus.d = 8'h02; bus.last = 1'b1; tick();
        bus.data_en = 1'b0; bus.last = 1'b0; tick();
        n_cmp++;
        if ({bus.done_o, bus.ok_o, bus.csum_o, bus.byte_cnt_o} !== {1'b1, 1'b0, 16'h0D0E, 16'd3}) begin
            n_err++; $display("FAIL b2b frame_b: got done=%b ok=%b csum=%h cnt=%0d want 1/0/0D0E/3",
                              bus.done_o, bus.ok_o, bus.csum_o, bus.byte_cnt_o);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        int seen_done;
        seen_done = 0;
        for (int i = 0; i < 5; i++) begin
            bus.d = 8'(8'h30 + i); bus.data_en = 1'b1; bus.last = 1'b0; bus.seed = 16'h5555; tick();
        end
        bus.data_en = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({bus.rdy_o, bus.busy_o, bus.done_o, bus.ok_o, bus.csum_o, bus.byte_cnt_o} !== {4'b1000, 16'h0, 16'h0}) begin
            n_err++; $display("FAIL reset_mid: got rdy=%b busy=%b done=%b ok=%b csum=%h cnt=%0d want 1/0/0/0/0000/0",
                              bus.rdy_o, bus.busy_o, bus.done_o, bus.ok_o, bus.csum_o, bus.byte_cnt_o);
        end
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            if (bus.done_o === 1'b1) seen_done++;
            tick();
        end
        n_cmp++;
        if (seen_done != 0) begin n_err++; $display("FAIL reset_mid no_done: got %0d pulses want 0", seen_done); end
        frm[0] = 8'h01; frm[1] = 8'h02; frm_len = 2;
        send_frame(16'h0000, 0, "after_reset");
        n_cmp++;
        if (bus.csum_o !== 16'hFEFD) begin n_err++; $display("FAIL after_reset const: got csum=%h want FEFD", bus.csum_o); end
        tick();
    endtask

    initial begin
        bus.d = 8'h00; bus.data_en = 1'b0; bus.last = 1'b0; bus.seed = 16'h0000;
        test_reset();
        test_ipv4();
        test_odd_and_carry();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/udp_csum_check.md
# udp_csum_check

Receive-side checksum verifier for the UDP/IP path. It accepts a byte stream that already contains its checksum field, such as an IPv4 header or a UDP pseudo-header + header + payload. It accumulates the RFC 1071 16-bit ones'-complement sum with end-around carry and reports whether the frame checks. It sits behind the Ethernet/IP byte parser and feeds the packet accept/drop decision; it is the counterpart of the transmit-side checksum generator.

## Interface
- No parameters; widths fixed (byte stream, 16-bit sum, 16-bit byte count).
- `clk_i`  in  1  single clock for all logic.
- `rst_n`  in  1  asynchronous, active-low reset.
- `d`  in  8  received byte, big-endian word order (first byte of a pair = high byte).
- `data_en`  in  1  `d` valid this cycle; accepted only when `rdy_o`=1.
- `last`  in  1  qualifies the final byte of the frame; ignored unless `data_en`=1.
- `seed`  in  16  initial partial sum (pseudo-header), sampled with the first byte of a frame.
- `rdy_o`  out  1  block can accept a byte.
- `busy_o`  out  1  frame in progress (ACC or FOLD).
- `done_o`  out  1  one-cycle pulse: results valid.
- `ok_o`  out  1  final sum == 16'hFFFF.
- `csum_o`  out  16  ones' complement of the final sum (0 when frame checks).
- `byte_cnt_o`  out  16  bytes accepted in the current/last frame, saturating at 16'hFFFF.

## Operation
- Reset values (async, `rst_n`=0): state=IDLE, `rdy_o`=1, `busy_o`=0, `done_o`=0, `ok_o`=0, `csum_o`=16'h0000, `byte_cnt_o`=0, accumulator=0, pending-high-byte flag=0.
- States:
  - IDLE: an accepted byte starts a frame.
  - ACC: accumulating bytes.
  - FOLD: absorbs the padded odd byte; `rdy_o`=0.
  - DONE: one cycle, `done_o`=1.
- Transitions:
  - IDLE/DONE → ACC on an accepted byte with `last`=0.
  - IDLE/DONE → FOLD on an accepted byte with `last`=1.
  - ACC → FOLD on an accepted byte with `last`=1.
  - FOLD → DONE unconditionally.
  - DONE → IDLE when no byte is accepted.
- `rdy_o`=1 in IDLE, ACC and DONE.
- DONE may accept the first byte of the next frame (back-to-back frames).
- Frame start: the accumulator loads `seed`, `byte_cnt_o` loads 1, and the first byte becomes the pending high byte. Outputs `ok_o` and `csum_o` keep their previous values until the next `done_o`.
- Even-position byte (0, 2, …): stored as the pending high byte.
- Odd-position byte: word = {pending, d}. Compute 17-bit s = acc + word, then acc ← s[15:0] + s[16]. The accumulator is always 16 bits after the add.
- Last byte at an even position (odd length): the word {d, 8'h00} is added in FOLD with the same end-around rule.
- Last byte at an odd position: nothing is left for FOLD; FOLD only holds the registered sum.
- Entering DONE: `ok_o` ← (acc == 16'hFFFF), `csum_o` ← ~acc.
- Gaps in `data_en` mid-frame are allowed; byte parity and state are held.
- `data_en`=1 while `rdy_o`=0 (FOLD): the byte is dropped and the count is unchanged. Upstream must respect `rdy_o`.
- `rst_n` asserted mid-frame: immediate return to reset values. No `done_o` is emitted for the aborted frame.

## Timing
- The last byte is accepted at edge E.
- FOLD occupies the cycle after E.
- `done_o`=1, with `ok_o` and `csum_o` updated, in the second cycle after E. Latency is 2 cycles from the last byte to `done_o`.
- `busy_o` is high from the cycle after the first accepted byte through FOLD.
- Minimum frame spacing: the next frame's first byte may be accepted in the DONE cycle. Throughput is 1 byte/cycle with 1 dead cycle (FOLD) per frame.
- A single-byte frame (first byte also `last`): seed + {d,00} is computed in FOLD; `done_o` follows after 2 cycles.
- All outputs are registered; there is no combinational path from inputs to outputs except `rdy_o`, which is decoded from state only.

## Test plan
- IPv4 header 4500 0073 0000 4000 4011 B861 C0A8 0001 C0A8 00C7 (20 bytes), seed 0, `last` on byte 20 → `done_o` 2 cycles later, `ok_o`=1, `csum_o`=0000, `byte_cnt_o`=20.
- Same header with B861 replaced by 0000 → `ok_o`=0, `csum_o`=B861.
- Odd length: bytes 01 02 03, seed 0 → sum 0402, `ok_o`=0, `csum_o`=FBFD, `byte_cnt_o`=3.
- Carry wrap: seed FFFF, bytes 00 01 → sum 0001 (end-around carry), `csum_o`=FFFE; seed FFFE, bytes 00 01 → `ok_o`=1.
- Back-to-back: frame A (2 bytes) with frame B's first byte in A's DONE cycle, plus a byte driven during FOLD → A's results correct, B unaffected, the FOLD byte is dropped and not counted.
- `rst_n` pulsed low mid-frame after 5 bytes → outputs return to reset values immediately with no `done_o`; the next frame 01 02 gives `csum_o`=FEFD.
